clk_period_meter: RTL and testbench

Measures an external clock or pulse train on the system clock: period and high time, both counted in system-clock cycles. Each start request arms one measurement. It is the receive-side counterpart of the programmable clock divider, and it lets software and the test bench confirm the frequency and duty cycle of any divided or external clock. It sits on the peripheral bus side of the SoC, with `sig_i` treated as fully asynchronous.

---
 rtl/clk_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 37 +++
 rtl/clk_period_meter.sv | 144 ++++++++++++++
 tb/tb_clk_period_meter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// clk_pkg: definitions shared by the clock-generation and clock-measurement
// peripherals.
//   DEFAULT_COUNTER_BITS : default counter width, shared with the clock divider
//   meter_state_e        : 2-bit FSM encoding of the period meter
package clk_pkg;

  localparam int DEFAULT_COUNTER_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous input into the clk domain through
// a SYNC_STAGES-deep flop chain and flags its edges.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   sig_i : asynchronous input
//   sig_s : synchronized level
//   rise  : one-cycle flag, sig_s went 0 -> 1
//   fall  : one-cycle flag, sig_s went 1 -> 0
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      sig_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d_q;
  assign fall  = ~sig_s & sig_d_q;

endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an asynchronous signal in
// system-clock cycles; each start request arms one measurement.
//   clk, reset : system clock, synchronous active-high reset
//   enable     : block enable, low aborts any measurement
//   start      : one-cycle arm request (accepted in IDLE with enable high)
//   sig_i      : asynchronous signal under measurement
//   timeout    : cycle budget from arm to result, 0 disables
//   period     : cycles between two consecutive rising edges
//   high_time  : cycles from the opening rise to the following fall
//   valid      : one-cycle pulse when period/high_time update
//   timed_out  : one-cycle pulse when the budget expires
//   busy       : high while armed or measuring
module clk_period_meter
  import clk_pkg::*;
#(
  parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    sig_i,
  input  logic [COUNTER_BITS-1:0] timeout,
  output logic [COUNTER_BITS-1:0] period,
  output logic [COUNTER_BITS-1:0] high_time,
  output logic                    valid,
  output logic                    timed_out,
  output logic                    busy
);

  localparam logic [COUNTER_BITS-1:0] ONE = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .sig_i(sig_i),
    .sig_s(),
    .rise (rise),
    .fall (fall)
  );

  meter_state_e            state_q;
  logic [COUNTER_BITS-1:0] cnt_q;
  logic [COUNTER_BITS-1:0] hi_cnt_q;
  logic [COUNTER_BITS-1:0] tmo_q;
  logic [COUNTER_BITS-1:0] period_q;
  logic [COUNTER_BITS-1:0] high_q;
  logic                    hi_seen_q;
  logic                    valid_q;
  logic                    timed_out_q;
  logic                    busy_q;

  logic [COUNTER_BITS-1:0] cnt_d;
  logic                    tmo_hit;

  // Saturating increment: a too-long measurement reports all-ones, never wraps.
  assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
  // Expiry is decided one count early so timed_out lands exactly `timeout`
  // cycles after busy rose.
  assign tmo_hit = (timeout != '0) && (tmo_q == timeout - ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_cnt_q    <= '0;
      tmo_q       <= '0;
      period_q    <= '0;
      high_q      <= '0;
      hi_seen_q   <= 1'b0;
      valid_q     <= 1'b0;
      timed_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      timed_out_q <= 1'b0;
      if (!enable) begin
        // Abort beats everything, including a closing rise this cycle.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= ARM;
              busy_q  <= 1'b1;
              tmo_q   <= '0;
            end
          end
          ARM: begin
            tmo_q <= tmo_q + ONE;
            if (tmo_hit) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              timed_out_q <= 1'b1;
            end else if (rise) begin
              state_q   <= MEAS;
              cnt_q     <= ONE;
              hi_cnt_q  <= '0;  // stays 0 if no fall precedes the closing rise
              hi_seen_q <= 1'b0;
            end
          end
          MEAS: begin
            tmo_q <= tmo_q + ONE;
            cnt_q <= cnt_d;
            if (fall && !hi_seen_q) begin
              hi_cnt_q  <= cnt_q;
              hi_seen_q <= 1'b1;
            end
            // Closing rise wins over a coincident timeout expiry.
            if (rise) begin
              period_q <= cnt_q;
              high_q   <= hi_cnt_q;
              valid_q  <= 1'b1;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
            end else if (tmo_hit) begin
              timed_out_q <= 1'b1;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timed_out = timed_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed bench for clk_period_meter. A 32-bit instance
// covers the main behaviour; a 4-bit instance sharing the same stimulus covers
// counter saturation.
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic        sig_i;
  logic [31:0] timeout;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        timed_out;
  logic        busy;

  logic [3:0]  timeout4;
  logic [3:0]  period4;
  logic [3:0]  high_time4;
  logic        valid4;
  logic        timed_out4;
  logic        busy4;

  always #5 clk = ~clk;

  clk_period_meter #(.COUNTER_BITS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .sig_i(sig_i),
    .timeout(timeout), .period(period), .high_time(high_time),
    .valid(valid), .timed_out(timed_out), .busy(busy)
  );

  clk_period_meter #(.COUNTER_BITS(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .sig_i(sig_i),
    .timeout(timeout4), .period(period4), .high_time(high_time4),
    .valid(valid4), .timed_out(timed_out4), .busy(busy4)
  );

  typedef struct {
    int hi;
    int lo;
    int exp_period;
    int exp_high;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Square-wave generator, driven on the falling edge.
  bit wave_on = 1'b0;
  bit level   = 1'b0;
  int wave_hi = 1;
  int wave_lo = 1;

  initial begin
    sig_i = 1'b0;
    forever begin
      if (wave_on) begin
        sig_i = 1'b1;
        repeat (wave_hi) @(negedge clk);
        sig_i = 1'b0;
        repeat (wave_lo) @(negedge clk);
      end else begin
        sig_i = level;
        @(negedge clk);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic stop_wave;
    wave_on = 1'b0;
    level   = 1'b0;
    repeat (50) @(negedge clk);
  endtask

  task automatic wait_result(input int budget, output bit got_v, output bit got_t);
    got_v = 1'b0;
    got_t = 1'b0;
    for (int i = 0; i < budget && !got_v && !got_t; i++) begin
      @(posedge clk);
      #1;
      got_v = valid;
      got_t = timed_out;
    end
  endtask

  initial begin
    vec_t vecs[5];
    bit   gv, gt;
    int   to_at, to_cnt;
    bit   saw_valid;

    vecs[0] = '{hi: 4, lo: 6, exp_period: 10, exp_high: 4};
    vecs[1] = '{hi: 3, lo: 3, exp_period: 6,  exp_high: 3};
    vecs[2] = '{hi: 1, lo: 1, exp_period: 2,  exp_high: 1};
    vecs[3] = '{hi: 7, lo: 2, exp_period: 9,  exp_high: 7};
    vecs[4] = '{hi: 2, lo: 9, exp_period: 11, exp_high: 2};

    reset = 1'b1; enable = 1'b0; start = 1'b0; timeout = 32'd0; timeout4 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset period", period, 32'd0);
    check("reset high_time", high_time, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset timed_out", {31'd0, timed_out}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven square-wave measurements
    for (int v = 0; v < 5; v++) begin
      wave_hi = vecs[v].hi;
      wave_lo = vecs[v].lo;
      pulse_start();
      wave_on = 1'b1;
      wait_result(100, gv, gt);
      $display("vector %0d: hi=%0d lo=%0d -> valid=%0d period=%0d high_time=%0d", v,
               vecs[v].hi, vecs[v].lo, gv, period, high_time);
      check($sformatf("vec%0d valid", v), {31'd0, gv}, 32'd1);
      check($sformatf("vec%0d period", v), period, vecs[v].exp_period);
      check($sformatf("vec%0d high_time", v), high_time, vecs[v].exp_high);
      check($sformatf("vec%0d busy drop", v), {31'd0, busy}, 32'd0);
      stop_wave();
    end

    // Timeout with sig held low; a start while busy must not restart the budget
    timeout = 32'd20;
    pulse_start();
    check("timeout busy rises", {31'd0, busy}, 32'd1);
    to_at = 0; to_cnt = 0; saw_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (timed_out) begin
        to_cnt++;
        if (to_at == 0) to_at = k;
      end
      if (valid) saw_valid = 1'b1;
    end
    $display("timeout: timed_out at cycle %0d, pulses=%0d", to_at, to_cnt);
    check("timeout cycle", to_at, 32'd20);
    check("timeout pulse width", to_cnt, 32'd1);
    check("timeout no valid", {31'd0, saw_valid}, 32'd0);
    check("timeout period kept", period, 32'd11);
    check("timeout high kept", high_time, 32'd2);
    check("timeout busy after", {31'd0, busy}, 32'd0);
    timeout = 32'd0;

    // Signal already high when armed
    level = 1'b1;
    repeat (10) @(negedge clk);
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check("prehigh still armed", {31'd0, busy}, 32'd1);
    check("prehigh no valid", {31'd0, valid}, 32'd0);
    wave_hi = 3; wave_lo = 3;
    wave_on = 1'b1;
    wait_result(100, gv, gt);
    $display("prehigh: valid=%0d period=%0d high_time=%0d", gv, period, high_time);
    check("prehigh valid", {31'd0, gv}, 32'd1);
    check("prehigh period", period, 32'd6);
    check("prehigh high_time", high_time, 32'd3);
    stop_wave();

    // Enable dropped mid-measurement
    wave_hi = 4; wave_lo = 6;
    pulse_start();
    wave_on = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    saw_valid = valid;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (valid) saw_valid = 1'b1;
    end
    $display("abort: busy=%0d valid_seen=%0d", busy, saw_valid);
    check("abort no valid", {31'd0, saw_valid}, 32'd0);
    check("abort period kept", period, 32'd6);
    stop_wave();
    pulse_start();
    wave_on = 1'b1;
    wait_result(100, gv, gt);
    $display("after abort: valid=%0d period=%0d high_time=%0d", gv, period, high_time);
    check("reenable valid", {31'd0, gv}, 32'd1);
    check("reenable period", period, 32'd10);
    check("reenable high_time", high_time, 32'd4);
    stop_wave();

    // Saturation on the 4-bit instance; bring both instances to IDLE first
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wave_hi = 20; wave_lo = 20;
    pulse_start();
    wave_on = 1'b1;
    wait_result(200, gv, gt);
    $display("saturation: valid4=%0d period4=%0d high_time4=%0d period=%0d high_time=%0d",
             valid4, period4, high_time4, period, high_time);
    check("sat32 valid", {31'd0, gv}, 32'd1);
    check("sat32 period", period, 32'd40);
    check("sat32 high_time", high_time, 32'd20);
    check("sat4 valid", {31'd0, valid4}, 32'd1);
    check("sat4 period", {28'd0, period4}, 32'd15);
    check("sat4 high_time", {28'd0, high_time4}, 32'd15);
    stop_wave();

    // Reset in the middle of a measurement
    wave_hi = 4; wave_lo = 6;
    pulse_start();
    wave_on = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset mid-meas: period=%0d high_time=%0d busy=%0d", period, high_time, busy);
    check("midreset period", period, 32'd0);
    check("midreset high_time", high_time, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset valid", {31'd0, valid}, 32'd0);
    check("midreset period4", {28'd0, period4}, 32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (valid || busy) saw_valid = 1'b1;
    end
    check("midreset stays idle", {31'd0, saw_valid}, 32'd0);
    stop_wave();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
